// File: rtl/sketch_ram_port_sched.sv
// Port-A scheduler for the sketch dual-port RAM: two-requester round-robin, zero-fill
// clear sweep, and read-response routing. Define SKETCH_RAM_AUTOCLR_EN to sweep on reset exit.
module sketch_ram_port_sched #(
  parameter int DataWidth   = 32,
  parameter int RAMAddWidth = 2,
  parameter int RdLatency   = 2
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   clr_done,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_we,
  input  logic [RAMAddWidth-1:0] req0_addr,
  input  logic [DataWidth-1:0]   req0_wdata,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_we,
  input  logic [RAMAddWidth-1:0] req1_addr,
  input  logic [DataWidth-1:0]   req1_wdata,
  output logic                   rsp0_valid,
  output logic                   rsp1_valid,
  output logic [DataWidth-1:0]   rsp_data,
  output logic [RAMAddWidth-1:0] address_a,
  output logic [DataWidth-1:0]   data_a,
  output logic                   rden_a,
  output logic                   wren_a,
  input  logic [DataWidth-1:0]   q_a
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  localparam logic [RAMAddWidth-1:0] LastAddr = '1;

  state_t                 state_q;
  logic                   clr_busy_q;
  logic                   clr_done_q;
  logic [RAMAddWidth-1:0] clr_addr_q;
  logic [RAMAddWidth-1:0] address_a_q;
  logic [DataWidth-1:0]   data_a_q;
  logic                   rden_a_q;
  logic                   wren_a_q;
  logic                   rr_last_q;
  tag_t                   tag_q [RdLatency+1];

  logic                   accept_ok;
  logic                   grant0;
  logic                   grant1;
  logic                   fire0;
  logic                   fire1;
  logic                   fire;
  logic                   cmd_we_d;
  logic [RAMAddWidth-1:0] cmd_addr_d;
  logic [DataWidth-1:0]   cmd_wdata_d;
  tag_t                   tag_d;

  // A pending clr_start takes the cycle, so nothing is accepted alongside it.
  assign accept_ok  = (state_q == ST_IDLE) && !clr_start;
  assign grant0     = req0_valid && (!req1_valid || rr_last_q);
  assign grant1     = req1_valid && (!req0_valid || !rr_last_q);
  assign req0_ready = accept_ok && grant0;
  assign req1_ready = accept_ok && grant1;
  assign fire0      = req0_valid && req0_ready;
  assign fire1      = req1_valid && req1_ready;
  assign fire       = fire0 || fire1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cmd_we_d    = req0_we;
    cmd_addr_d  = req0_addr;
    cmd_wdata_d = req0_wdata;
    if (fire1) begin
      cmd_we_d    = req1_we;
      cmd_addr_d  = req1_addr;
      cmd_wdata_d = req1_wdata;
    end
    tag_d.valid = fire && !cmd_we_d;
    tag_d.id    = fire1;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (aclr) begin
`ifdef SKETCH_RAM_AUTOCLR_EN
      state_q    <= ST_CLEAR;
      clr_busy_q <= 1'b1;
      wren_a_q   <= 1'b1;
`else
      state_q    <= ST_IDLE;
      clr_busy_q <= 1'b0;
      wren_a_q   <= 1'b0;
`endif
      clr_done_q  <= 1'b0;
      clr_addr_q  <= '0;
      address_a_q <= '0;
      data_a_q    <= '0;
      rden_a_q    <= 1'b0;
      rr_last_q   <= 1'b1;
    end else begin
      clr_done_q <= 1'b0;
      rden_a_q   <= 1'b0;
      wren_a_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
            state_q     <= ST_CLEAR;
            clr_busy_q  <= 1'b1;
            clr_addr_q  <= '0;
            address_a_q <= '0;
            data_a_q    <= '0;
            wren_a_q    <= 1'b1;
          end else if (fire) begin
            rr_last_q   <= fire1;
            address_a_q <= cmd_addr_d;
            data_a_q    <= cmd_wdata_d;
            rden_a_q    <= !cmd_we_d;
            wren_a_q    <= cmd_we_d;
          end
        end
        ST_CLEAR: begin
          // clr_addr_q is the address being written this cycle; stop after the top word.
          if (clr_addr_q == LastAddr) begin
            state_q    <= ST_IDLE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            clr_addr_q  <= clr_addr_q + 1'b1;
            address_a_q <= clr_addr_q + 1'b1;
            data_a_q    <= '0;
            wren_a_q    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      // NOTE: this small array holds valid bits, so unlike a data memory it must be reset.
      for (int i = 0; i <= RdLatency; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i <= RdLatency; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign clr_busy   = clr_busy_q;
  assign clr_done   = clr_done_q;
  assign address_a  = address_a_q;
  assign data_a     = data_a_q;
  assign rden_a     = rden_a_q;
  assign wren_a     = wren_a_q;
  assign rsp0_valid = tag_q[RdLatency].valid && !tag_q[RdLatency].id;
  assign rsp1_valid = tag_q[RdLatency].valid && tag_q[RdLatency].id;
  assign rsp_data   = q_a;

endmodule

// File: tb/tb_sketch_ram_port_sched.sv
// Bench for sketch_ram_port_sched: transaction-level port-A model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sketch_ram_port_sched;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int RL = 2;
  localparam int WORDS = 1 << AW;

  logic          clock = 1'b0;
  logic          aclr = 1'b1;
  logic          clr_start = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          clr_busy, clr_done, req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp_data, data_a, q_a;
  logic [AW-1:0] address_a;
  logic          rden_a, wren_a;

  sketch_ram_port_sched #(.DataWidth(DW), .RAMAddWidth(AW), .RdLatency(RL)) dut (
    .clock(clock), .aclr(aclr), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .address_a(address_a), .data_a(data_a), .rden_a(rden_a), .wren_a(wren_a), .q_a(q_a)
  );

  always #5 clock = ~clock;

  // RAM wrapper port A: write on the edge, read data appears RL cycles after rden_a.
  logic [DW-1:0] ram [WORDS];
  logic [DW-1:0] rd_s1 = '0, rd_s2 = '0;
  always @(posedge clock) begin
    if (wren_a) ram[address_a] <= data_a;
    if (rden_a) rd_s1 <= ram[address_a];
    rd_s2 <= rd_s1;
  end
  assign q_a = rd_s2;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction-level model: expected port-A command each cycle and a list of due responses.
  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          rsp_q[$];
  logic [DW-1:0] m_mem [WORDS];
  bit            m_live = 0;
  bit            m_busy = 0, m_done = 0, m_rr = 1, m_rden = 0, m_wren = 0, m_rd_id = 0;
  int            m_sweep_next = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            cyc = 0;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end
  end

  always @(negedge clock) begin : cmp
    bit   e_r0, e_r1, g, due_now;
    rsp_t r;
    e_r0 = !m_busy && !clr_start && req0_valid && (!req1_valid || m_rr);
    e_r1 = !m_busy && !clr_start && req1_valid && (!req0_valid || !m_rr);
    if (m_live) begin
      due_now = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
      check("req0_ready", req0_ready, e_r0);
      check("req1_ready", req1_ready, e_r1);
      check("clr_busy", clr_busy, m_busy);
      check("clr_done", clr_done, m_done);
      check("rden_a", rden_a, m_rden);
      check("wren_a", wren_a, m_wren);
      check("address_a", address_a, m_addr);
      check("data_a", data_a, m_data);
      if (due_now) begin
        r = rsp_q.pop_front();
        check("rsp0_valid", rsp0_valid, !r.id);
        check("rsp1_valid", rsp1_valid, r.id);
        check("rsp_data", rsp_data, r.data);
      end else begin
        check("rsp0_valid", rsp0_valid, 0);
        check("rsp1_valid", rsp1_valid, 0);
      end
    end
    // The command on the port this cycle takes effect in the RAM at the coming edge.
    if (m_live && m_rden) begin
      r.due  = cyc + RL;
      r.id   = m_rd_id;
      r.data = m_mem[m_addr];
      rsp_q.push_back(r);
    end
    if (m_live && m_wren) m_mem[m_addr] = m_data;
    m_done = 0;
    m_rden = 0;
    m_wren = 0;
    if (aclr) begin
      m_live = 1;
      m_rr   = 1;
      m_addr = '0;
      m_data = '0;
      rsp_q.delete();
`ifdef SKETCH_RAM_AUTOCLR_EN
      m_busy       = 1;
      m_wren       = 1;
      m_sweep_next = 1;
`else
      m_busy = 0;
`endif
    end else if (m_live) begin
      if (m_busy) begin
        if (m_sweep_next == WORDS) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_wren = 1;
          m_addr = m_sweep_next[AW-1:0];
          m_data = '0;
          m_sweep_next++;
        end
      end else if (clr_start) begin
        m_busy       = 1;
        m_wren       = 1;
        m_addr       = '0;
        m_data       = '0;
        m_sweep_next = 1;
      end else if (e_r0 || e_r1) begin
        g       = e_r1;
        m_rr    = g;
        m_rd_id = g;
        m_wren  = g ? req1_we : req0_we;
        m_rden  = !m_wren;
        m_addr  = g ? req1_addr : req0_addr;
        m_data  = g ? req1_wdata : req0_wdata;
      end
    end
    cyc++;
  end

  typedef struct {
    bit            id;
    logic [DW-1:0] data;
  } log_t;
  log_t rsp_log[$];

  always @(negedge clock) begin : recorder
    log_t e;
    if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
      e.id   = rsp1_valid;
      e.data = rsp_data;
      rsp_log.push_back(e);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int busy_cnt, done_cnt, hit_cnt;
  bit found;

  initial begin
`ifdef SKETCH_RAM_AUTOCLR_EN
    req1_valid = 1'b1;
    req1_addr  = 4'd9;
`endif
    repeat (2) step();
    aclr = 1'b0;
`ifdef SKETCH_RAM_AUTOCLR_EN
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (i == 0) check("ac_busy_first", clr_busy, 1);
      if (clr_busy) begin
        busy_cnt++;
        check("ac_ready1_busy", req1_ready, 0);
      end
      if (clr_done) begin
        done_cnt++;
        check("ac_ready1_done", req1_ready, 1);
      end
      step();
      if (done_cnt > 0) req1_valid = 1'b0;
    end
    check("ac_busy_cycles", busy_cnt, 16);
    check("ac_done_pulses", done_cnt, 1);
`else
    // 1: write then immediate read of the same address by the other requester.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'd3; req0_wdata = 32'hA5A5_0001;
    @(negedge clock);
    check("t1_wr_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd3;
    @(negedge clock);
    check("t1_rd_ready", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("t1_rsp1_early", rsp1_valid, 0);
      check("t1_rsp0_early", rsp0_valid, 0);
      step();
    end
    @(negedge clock);
    check("t1_rsp1_valid", rsp1_valid, 1);
    check("t1_rsp0_valid", rsp0_valid, 0);
    check("t1_rsp_data", rsp_data, 32'hA5A5_0001);
    step();

    // 2: both requesters contend for four cycles.
    rsp_log.delete();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd3;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("t2_ready0_%0d", i), req0_ready, (i % 2) == 0);
      check($sformatf("t2_ready1_%0d", i), req1_ready, (i % 2) == 1);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step();
    check("t2_rsp_count", rsp_log.size(), 4);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++) begin
      check($sformatf("t2_rsp_id_%0d", i), rsp_log[i].id, (i % 2) == 1);
      check($sformatf("t2_rsp_data_%0d", i), rsp_log[i].data, (i % 2) == 0 ? 32'hA5A5_0001 : 32'h0);
    end

    // 3 and 5: fill, read in flight, then clear started alongside a req0 request.
    for (int i = 0; i < WORDS; i++) begin
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = i[AW-1:0]; req0_wdata = 32'hFFFF_FFFF;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd5;
    step();
    req1_valid = 1'b0;
    clr_start = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd2;
    @(negedge clock);
    check("t5_clr_wins", req0_ready, 0);
    step();
    clr_start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (clr_busy) begin
        busy_cnt++;
        check("t3_ready0_busy", req0_ready, 0);
        check("t3_ready1_busy", req1_ready, 0);
      end
      if (clr_done) begin
        done_cnt++;
        check("t5_accept_at_done", req0_ready, 1);
      end
      step();
      if (done_cnt > 0) req0_valid = 1'b0;
    end
    check("t3_busy_cycles", busy_cnt, 16);
    check("t3_done_pulses", done_cnt, 1);
    rsp_log.delete();
    for (int i = 0; i < WORDS; i++) begin
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = i[AW-1:0];
      step();
    end
    req1_valid = 1'b0;
    repeat (4) step();
    hit_cnt = 0;
    foreach (rsp_log[i]) if (rsp_log[i].id && rsp_log[i].data == 32'h0) hit_cnt++;
    check("t3_zero_reads", hit_cnt, 16);

    // 4: reset while the sweep is writing address 7.
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (wren_a && address_a == 4'd6) found = 1;
      else step();
    end
    check("t4_reach_addr6", found, 1);
    step();
    aclr = 1'b1;
    @(negedge clock);
    check("t4_addr7", address_a, 7);
    step();
    aclr = 1'b0;
    @(negedge clock);
    check("t4_busy", clr_busy, 0);
    check("t4_done", clr_done, 0);
    check("t4_address", address_a, 0);
    check("t4_data", data_a, 0);
    check("t4_rden", rden_a, 0);
    check("t4_wren", wren_a, 0);
    check("t4_rsp0", rsp0_valid, 0);
    check("t4_rsp1", rsp1_valid, 0);
    step();
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (clr_done) done_cnt++;
      step();
    end
    check("t4_no_done", done_cnt, 0);

    // After reset req0 wins the first contest.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd3;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd12;
    @(negedge clock);
    check("rst_rr_ready0", req0_ready, 1);
    check("rst_rr_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
`endif
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
